// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg: shared types and constants for the decoder scan sequencer.
//   CW / DW      : slot (decoder count) width and dwell counter width
//   slot_t       : one decoder slot index
//   dwell_t      : dwell length / dwell counter value
//   scan_state_t : sequencer states, also exported on the debug state port
//   norm_dwell() : maps a programmed dwell of 0 onto 1
package dec_scan_pkg;

  localparam int CW = 8;
  localparam int DW = 8;

  typedef logic [CW-1:0] slot_t;
  typedef logic [DW-1:0] dwell_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  function automatic dwell_t norm_dwell(input dwell_t d);
    return (d == '0) ? dwell_t'(1) : d;
  endfunction

endpackage

// File: rtl/dec_scan_dwell.sv
// dec_scan_dwell: dwell counter for one slot.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset
//   clr_i   : load the counter with 1 (first cycle of a slot follows)
//   en_i    : advance the counter by one
//   limit_i : latched dwell length (never 0)
//   hit_o   : counter equals limit_i, i.e. this is the last dwell cycle
// The counter never passes limit_i because the sequencer leaves SCAN on hit,
// so it cannot wrap.
module dec_scan_dwell
  import dec_scan_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clr_i,
  input  logic   en_i,
  input  dwell_t limit_i,
  output logic   hit_o
);

  dwell_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = dwell_t'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + dwell_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= dwell_t'(1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/dec_scan_ctrl.sv
// dec_scan_ctrl: steps the 8-bit count of the 256-line select decoder
// through a programmed slot range, holding sel_en high for dwell cycles
// per slot with a one-cycle dead gap between slots (break-before-make).
//
// Optional feature: define DEC_SCAN_REPEAT_EN to add the rpt_i port; a scan
// started with rpt_i high loops over the range until stop_i.
//
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous active-low reset
//   start_i    : begin a scan (IDLE only; ignored together with stop_i)
//   stop_i     : abort a scan in SCAN or GAP
//   first_i    : first slot, sampled on start
//   last_i     : last slot, sampled on start (last < first wraps 255->0)
//   dwell_i    : cycles per slot, sampled on start (0 acts as 1)
//   rpt_i      : repeat mode, sampled on start (DEC_SCAN_REPEAT_EN only)
//   count_o    : slot index to the decoder
//   sel_en_o   : select enable, high while a slot dwells
//   busy_o     : high in SCAN and GAP
//   done_o     : one-cycle pulse on normal completion
//   aborted_o  : one-cycle pulse when stop ends a scan
//   state_o    : current sequencer state (scan_state_t encoding)
//
// Handshake: start_i is a request accepted on any edge where the block is
// in IDLE and stop_i is low; there is no acknowledge other than busy_o
// rising on the following cycle. Every output comes straight from a
// register or a decode of the state register only.
module dec_scan_ctrl
  import dec_scan_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [CW-1:0] first_i,
  input  logic [CW-1:0] last_i,
  input  logic [DW-1:0] dwell_i,
`ifdef DEC_SCAN_REPEAT_EN
  input  logic          rpt_i,
`endif
  output logic [CW-1:0] count_o,
  output logic          sel_en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic [1:0]    state_o
);

  scan_state_t state_q, state_d;
  slot_t       count_q, count_d;
  slot_t       first_q, first_d;
  slot_t       last_q,  last_d;
  dwell_t      dwell_q, dwell_d;
  logic        aborted_q, aborted_d;
  logic        dw_clr, dw_en, dw_hit;
  logic        rpt_now;

`ifdef DEC_SCAN_REPEAT_EN
  logic rpt_q, rpt_d;
  assign rpt_now = rpt_q;
`else
  assign rpt_now = 1'b0;
`endif

  dec_scan_dwell u_dwell (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (dw_clr),
    .en_i    (dw_en),
    .limit_i (dwell_q),
    .hit_o   (dw_hit)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    first_d   = first_q;
    last_d    = last_q;
    dwell_d   = dwell_q;
    aborted_d = 1'b0;
    dw_clr    = 1'b0;
    dw_en     = 1'b0;
`ifdef DEC_SCAN_REPEAT_EN
    rpt_d     = rpt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          first_d = first_i;
          last_d  = last_i;
          dwell_d = norm_dwell(dwell_i);
`ifdef DEC_SCAN_REPEAT_EN
          rpt_d   = rpt_i;
`endif
          count_d = first_i;
          dw_clr  = 1'b1;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (stop_i) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (dw_hit) begin
          // count only moves on the edge into GAP, so the decoder input is
          // stable for the whole time sel_en is high.
          if (count_q != last_q) begin
            count_d = count_q + slot_t'(1);
            state_d = GAP;
          end else if (rpt_now) begin
            count_d = first_q;
            state_d = GAP;
          end else begin
            state_d = DONE;
          end
        end else begin
          dw_en = 1'b1;
        end
      end

      GAP: begin
        if (stop_i) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          dw_clr  = 1'b1;
          state_d = SCAN;
        end
      end

      DONE: begin
        // stop is deliberately ignored here so the completion pulse is kept
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      count_q   <= '0;
      first_q   <= '0;
      last_q    <= '0;
      dwell_q   <= dwell_t'(1);
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      first_q   <= first_d;
      last_q    <= last_d;
      dwell_q   <= dwell_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef DEC_SCAN_REPEAT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rpt_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  assign count_o   = count_q;
  assign sel_en_o  = (state_q == SCAN);
  assign busy_o    = (state_q == SCAN) || (state_q == GAP);
  assign done_o    = (state_q == DONE);
  assign aborted_o = aborted_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// tb_dec_scan_ctrl: self-checking bench for dec_scan_ctrl. The reference
// model expands a scan request into the per-cycle output trace the block
// must produce (slot list, dwell cycles, gaps, done/idle tail, stop cut).
// Define DEC_SCAN_REPEAT_EN for the repeat-mode scenario as well.
module tb_dec_scan_ctrl;
  import dec_scan_pkg::*;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [CW-1:0] first_i = '0;
  logic [CW-1:0] last_i = '0;
  logic [DW-1:0] dwell_i = '0;
  logic          rpt_i = 1'b0;
  logic [CW-1:0] count_o;
  logic          sel_en_o, busy_o, done_o, aborted_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_errors = 0;
  slot_t idle_count = '0;

  // trace entry: {count, sel_en, busy, done, aborted}
  logic [11:0] exp_q[$];

  dec_scan_ctrl dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .first_i   (first_i),
    .last_i    (last_i),
    .dwell_i   (dwell_i),
`ifdef DEC_SCAN_REPEAT_EN
    .rpt_i     (rpt_i),
`endif
    .count_o   (count_o),
    .sel_en_o  (sel_en_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .aborted_o (aborted_o),
    .state_o   (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {count_o, sel_en_o, busy_o, done_o, aborted_o};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: build the expected trace for cycles 1.. after the start edge.
  task automatic build_exp(input slot_t f, input slot_t l, input dwell_t d,
                           input bit rpt, input int stop_cyc);
    int n  = ((int'(l) - int'(f)) & 255) + 1;
    int dd = (d == 0) ? 1 : int'(d);
    int k  = 0;
    logic [11:0] tr[$];
    slot_t cur;
    while (1) begin
      cur = f + slot_t'(k % n);
      for (int j = 0; j < dd; j++) tr.push_back({cur, 4'b1100});
      if ((k % n) == n - 1 && !rpt) break;
      tr.push_back({slot_t'(f + slot_t'((k + 1) % n)), 4'b0100});
      k++;
      if (rpt && tr.size() > stop_cyc + 2) break;
    end
    if (!rpt) begin
      tr.push_back({l, 4'b0010});
      tr.push_back({l, 4'b0000});
    end
    exp_q.delete();
    if (stop_cyc > 0 && stop_cyc <= tr.size() && tr[stop_cyc-1][2]) begin
      for (int i = 0; i < stop_cyc; i++) exp_q.push_back(tr[i]);
      exp_q.push_back({tr[stop_cyc-1][11:4], 4'b0001});
    end else begin
      exp_q = tr;
    end
  endtask

  // driver: start a scan on the next edge, then follow it cycle by cycle
  task automatic run_scan(input string name, input slot_t f, input slot_t l,
                          input dwell_t d, input bit rpt, input int stop_cyc,
                          input bit noise);
    int c = 0;
    logic [11:0] e;
    build_exp(f, l, d, rpt, stop_cyc);
    start_i = 1'b1; stop_i = 1'b0;
    first_i = f; last_i = l; dwell_i = d; rpt_i = rpt;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (exp_q.size() > 0) begin
      c++;
      e = exp_q.pop_front();
      check_eq($sformatf("%s cyc%0d", name, c), {20'd0, obs()}, {20'd0, e});
      idle_count = e[11:4];
      if (noise) begin
        first_i = slot_t'($urandom); last_i = slot_t'($urandom);
        dwell_i = dwell_t'($urandom); rpt_i = 1'($urandom);
        start_i = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      stop_i = (c == stop_cyc);
      if (exp_q.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    stop_i = 1'b0; start_i = 1'b0;
  endtask

  initial begin
    slot_t  f, l;
    dwell_t d;
    int     sc;

    // reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset outputs", {20'd0, obs()}, 32'd0);
    check_eq("reset state", {30'd0, state_o}, {30'd0, IDLE});
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check_eq("idle after reset", {20'd0, obs()}, 32'd0);

    // directed scenarios
    run_scan("basic", 8'd0, 8'd2, 8'd3, 1'b0, 0, 1'b1);
    run_scan("wrap_dw0", 8'd254, 8'd1, 8'd0, 1'b0, 0, 1'b0);
    run_scan("single", 8'd130, 8'd130, 8'd5, 1'b0, 0, 1'b1);
    run_scan("abort_gap2", 8'd0, 8'd9, 8'd2, 1'b0, 6, 1'b0);
    run_scan("after_abort", 8'd5, 8'd6, 8'd1, 1'b0, 0, 1'b0);
    run_scan("stop_in_done", 8'd7, 8'd8, 8'd1, 1'b0, 4, 1'b0);

    // start together with stop in IDLE is ignored
    start_i = 1'b1; stop_i = 1'b1; first_i = 8'd40; last_i = 8'd41; dwell_i = 8'd2;
    @(posedge clk); #1;
    start_i = 1'b0; stop_i = 1'b0;
    check_eq("start+stop ignored", {20'd0, obs()}, {20'd0, idle_count, 4'b0000});
    @(posedge clk); #1;
    check_eq("start+stop still idle", {30'd0, state_o}, {30'd0, IDLE});

    // randomized scans
    for (int i = 0; i < 8; i++) begin
      f  = slot_t'($urandom);
      l  = f + slot_t'($urandom_range(0, 5));
      d  = dwell_t'($urandom_range(0, 4));
      sc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0;
      run_scan($sformatf("rand%0d", i), f, l, d, 1'b0, sc, 1'b1);
    end

`ifdef DEC_SCAN_REPEAT_EN
    run_scan("repeat", 8'd3, 8'd4, 8'd2, 1'b1, 20, 1'b0);
    run_scan("after_repeat", 8'd1, 8'd1, 8'd1, 1'b0, 0, 1'b0);
`endif

    // reset asserted mid-scan
    start_i = 1'b1; first_i = 8'd20; last_i = 8'd30; dwell_i = 8'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid-scan busy", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check_eq("mid-scan reset outputs", {20'd0, obs()}, 32'd0);
    check_eq("mid-scan reset state", {30'd0, state_o}, {30'd0, IDLE});
    rst_ni = 1'b1;
    idle_count = '0;
    @(posedge clk); #1;
    run_scan("post_reset", 8'd255, 8'd0, 8'd2, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
